// File: rtl/spike_event_fifo.sv
// Spike edge capture: timestamps rising edges of a LIF spike into a small FIFO.
// Define SPIKE_ISI_EN to store inter-spike intervals instead of absolute time.
module spike_event_fifo #(
    parameter int DEPTH    = 4,
    parameter int TS_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       spike,
    output logic [TS_WIDTH-1:0]        rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 spike_count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [AW-1:0]       PTR_ONE  = AW'(1);
    localparam logic [LW-1:0]       LVL_ONE  = LW'(1);
    localparam logic [LW-1:0]       LVL_FULL = LW'(DEPTH);
    localparam logic [TS_WIDTH-1:0] TS_ONE   = TS_WIDTH'(1);
    localparam logic [TS_WIDTH-1:0] TS_MAX   = '1;

    logic                spike_q;
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic [TS_WIDTH-1:0] mem [DEPTH];
    logic [TS_WIDTH-1:0] stamp;

    logic edge_seen;
    logic full;
    logic accept;
    logic pop;
    logic push;
    logic drop;

    assign edge_seen = spike & ~spike_q & enable;
    assign full      = (level == LVL_FULL);
    assign rd_valid  = (level != '0);
    assign rd_data   = rd_valid ? mem[rptr] : '0;

    // clear and reset both outrank any push or pop in the same cycle
    assign accept = edge_seen & ~clear & ~reset;
    assign pop    = rd_valid & rd_ready & ~clear & ~reset;
    assign push   = accept & (~full | pop);
    assign drop   = accept & full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike;
        end
    end

`ifdef SPIKE_ISI_EN
    logic [TS_WIDTH-1:0] isi;

    // interval restarts at 1 so the next entry counts the event cycle itself
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            isi <= '0;
        end else if (enable) begin
            if (edge_seen) begin
                isi <= TS_ONE;
            end else if (isi != TS_MAX) begin
                isi <= isi + TS_ONE;
            end
        end
    end

    assign stamp = isi;
`else
    logic [TS_WIDTH-1:0] ts;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ts <= '0;
        end else if (enable) begin
            ts <= ts + TS_ONE;
        end
    end

    assign stamp = ts;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= stamp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // dropped events still count toward activity
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            spike_count <= 8'd0;
            overflow    <= 1'b0;
        end else begin
            if (accept && spike_count != 8'hFF) begin
                spike_count <= spike_count + 8'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
